// File: rtl/meteor_game_scheduler.sv
// meteor_game_scheduler: START/PLAY/OVER sequencing, LFSR respawn params, difficulty ramp and lives; HIGH_SCORE_EN adds high_score
module meteor_game_scheduler #(
  parameter int LIVES = 3,
  parameter int LEVEL_STEP = 16,
  parameter int MAX_LEVEL = 7,
  parameter int XSPD_LEVEL = 2,
  parameter int INVULN_FRAMES = 60,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic        start_key,
  input  logic        player_hit,
  input  logic [23:0] score,
  output logic        start_screen,
  output logic        game_over,
  output logic [9:0]  set_position_x,
  output logic [4:0]  x_speed,
  output logic [4:0]  y_speed,
  output logic        sign,
  output logic [3:0]  level,
  output logic [2:0]  lives,
  output logic        invuln
`ifdef HIGH_SCORE_EN
  ,
  output logic [23:0] high_score
`endif
);
  typedef enum logic [1:0] {START, PLAY, OVER} state_t;
  localparam logic [2:0] LIVES_L = 3'(LIVES);
  localparam logic [3:0] MAX_L = 4'(MAX_LEVEL);
  localparam logic [3:0] XSPD_L = 4'(XSPD_LEVEL);
  localparam logic [23:0] STEP_L = 24'(LEVEL_STEP);
  localparam logic [15:0] INV_L = 16'(INVULN_FRAMES - 1);
  state_t state, state_n;
  logic key_q, key_rise, hit, lvl_up;
  logic [15:0] lfsr, lfsr_n, inv_cnt, inv_cnt_n;
  logic [23:0] next_thr, next_thr_n;
  logic [24:0] thr_sum;
  logic [3:0] level_n;
  logic [2:0] lives_n;
  logic invuln_n;
  logic [9:0] raw;
  always_comb begin
    key_rise = start_key & ~key_q;
    lfsr_n = (lfsr == 16'd0) ? LFSR_SEED : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    raw = (lfsr_n[9:0] >= 10'd596) ? lfsr_n[9:0] - 10'd512 : lfsr_n[9:0];
    hit = player_hit & ~invuln;
    lvl_up = (score >= next_thr) && (level < MAX_L);
    thr_sum = {1'b0, next_thr} + {1'b0, STEP_L};
    state_n = state;
    level_n = level;
    lives_n = lives;
    invuln_n = invuln;
    inv_cnt_n = inv_cnt;
    next_thr_n = next_thr;
    case (state)
      START: if (key_rise) begin
        state_n = PLAY;
        lives_n = LIVES_L;
        level_n = 4'd0;
        next_thr_n = STEP_L;
        invuln_n = 1'b0;
        inv_cnt_n = 16'd0;
      end
      PLAY: begin
        if (lvl_up) begin
          level_n = level + 4'd1;
          next_thr_n = thr_sum[24] ? 24'hFFFFFF : thr_sum[23:0];
        end
        if (hit) begin
          lives_n = lives - 3'd1;
          invuln_n = 1'b1;
          inv_cnt_n = INV_L;
          state_n = (lives == 3'd1) ? OVER : PLAY;
        end else if (invuln) begin
          invuln_n = inv_cnt != 16'd0;
          inv_cnt_n = (inv_cnt == 16'd0) ? 16'd0 : inv_cnt - 16'd1;
        end
      end
      OVER: state_n = key_rise ? START : OVER;
      default: state_n = START;
    endcase
  end
  always_ff @(posedge frame_clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= START;
      start_screen <= 1'b1;
      game_over <= 1'b0;
      lfsr <= LFSR_SEED;
      level <= 4'd0;
      lives <= LIVES_L;
      invuln <= 1'b0;
      inv_cnt <= 16'd0;
      next_thr <= STEP_L;
      key_q <= 1'b1;
      set_position_x <= 10'd10;
      x_speed <= 5'd0;
      y_speed <= 5'd0;
      sign <= 1'b0;
`ifdef HIGH_SCORE_EN
      high_score <= 24'd0;
`endif
    end else begin
      state <= state_n;
      start_screen <= state_n == START;
      game_over <= state_n == OVER;
      lfsr <= lfsr_n;
      level <= level_n;
      lives <= lives_n;
      invuln <= invuln_n;
      inv_cnt <= inv_cnt_n;
      next_thr <= next_thr_n;
      key_q <= start_key;
      set_position_x <= raw + 10'd10;
      x_speed <= (level_n >= XSPD_L) ? {4'b0, lfsr_n[13]} : 5'd0;
      y_speed <= {1'b0, level_n};
      sign <= lfsr_n[14];
`ifdef HIGH_SCORE_EN
      if (state == PLAY && state_n == OVER && score > high_score) high_score <= score;
`endif
    end
endmodule
